// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control/handshake inputs, and the pc_register/memory/IR-side outputs.
// The master modport is the sequencer side and the slave modport is the environment side.
interface fetch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  start;
    logic                  halt;
    logic                  mem_rdy;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ir_ready;
    logic                  pc_cs;
    logic                  pc_oe_a;
    logic                  pc_cnt_en;
    logic                  mem_cs;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] ir_out;
    logic                  ir_valid;
    logic                  busy;
    logic                  err;
    logic [CNT_WIDTH-1:0]  fetch_count;

    modport master (
        input  start, halt, mem_rdy, data_in, ir_ready,
        output pc_cs, pc_oe_a, pc_cnt_en, mem_cs, mem_oe,
               ir_out, ir_valid, busy, err, fetch_count
    );

    modport slave (
        output start, halt, mem_rdy, data_in, ir_ready,
        input  pc_cs, pc_oe_a, pc_cnt_en, mem_cs, mem_oe,
               ir_out, ir_valid, busy, err, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: strobes pc_register and memory, latches each fetched byte into
// the IR and presents it to decode with a valid/ready handshake. All outputs are registered-state decodes.
module fetch_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  cnt_en_q, cnt_en_d;
    logic                  err_q, err_d;
    logic                  halt_q, halt_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            err_q      <= 1'b0;
            halt_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            cnt_en_q   <= cnt_en_d;
            err_q      <= err_d;
            halt_q     <= halt_d;
            count_q    <= count_d;
        end
    end

    // halt seen at any point of a fetch is remembered so the FSM stops after the HOLD handshake
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        cnt_en_d   = 1'b0;
        err_d      = err_q;
        halt_d     = halt_q;
        count_d    = count_q;
        unique case (state_q)
            S_IDLE: begin
                halt_d = 1'b0;
                if (bus.start && !bus.halt && !err_q) state_d = S_ADDR;
            end
            S_ADDR: begin
                wait_d = '0;
                if (bus.halt) halt_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.halt) halt_d = 1'b1;
                if (bus.mem_rdy) begin
                    ir_d       = bus.data_in;
                    ir_valid_d = 1'b1;
                    count_d    = count_q + 1'b1;
                    cnt_en_d   = 1'b1;
                    state_d    = S_HOLD;
                end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = (bus.halt || halt_q) ? S_IDLE : S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic strobe;
    assign strobe = (state_q == S_ADDR) || (state_q == S_WAIT);

    assign bus.pc_cs       = strobe;
    assign bus.pc_oe_a     = strobe;
    assign bus.mem_cs      = strobe;
    assign bus.mem_oe      = strobe;
    assign bus.pc_cnt_en   = cnt_en_q;
    assign bus.ir_out      = ir_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err         = err_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scripted and randomized fetches checked against a
// fetch-schedule model (ADDR 1 cycle, WAIT until mem_rdy, HOLD until ir_ready) kept in the bench.
module tb_fetch_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned NF = 12;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_count = 0;
    int   pulses = 0;
    logic [DW-1:0] exp_ir = '0;
    logic [DW-1:0] b2b_data [0:2] = '{8'hAD, 8'hFF, 8'h67};
    logic [3:0] strobes;

    fetch_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fetch_sequencer #(.DATA_WIDTH(DW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign strobes = {bus.pc_cs, bus.pc_oe_a, bus.mem_cs, bus.mem_oe};

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.pc_cnt_en === 1'b1) pulses++;
    endtask

    function automatic int next_count(int c);
        return (c + 1) % (1 << CW);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.halt = 1'b0; bus.mem_rdy = 1'b0;
        bus.data_in = '0; bus.ir_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({strobes, bus.pc_cnt_en, bus.ir_valid, bus.busy, bus.err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {strobes, bus.pc_cnt_en, bus.ir_valid, bus.busy, bus.err});
        end
        n_checks++;
        if (bus.ir_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_ir: got %h expected 00", bus.ir_out);
        end
        n_checks++;
        if (bus.fetch_count !== 2'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fetch_count);
        end
        reset = 1'b0;
        exp_count = 0;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || strobes !== 4'h0) begin
            n_fail++; $display("FAIL reset_release_idle: got busy=%b strobes=%h expected 0/0", bus.busy, strobes);
        end
    endtask

    task automatic test_single();
        bus.data_in = 8'hBF; bus.mem_rdy = 1'b1; bus.ir_ready = 1'b1;
        bus.start = 1'b1; bus.halt = 1'b0; pulses = 0;
        tick();
        bus.start = 1'b0; bus.halt = 1'b1;
        n_checks++;
        if (strobes !== 4'hF || bus.busy !== 1'b1 || bus.ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_addr: got strobes=%h busy=%b valid=%b expected f/1/0", strobes, bus.busy, bus.ir_valid);
        end
        tick();
        n_checks++;
        if (strobes !== 4'hF || bus.ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_wait: got strobes=%h valid=%b expected f/0", strobes, bus.ir_valid);
        end
        tick();
        exp_count = next_count(exp_count);
        exp_ir = 8'hBF;
        n_checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir || bus.pc_cnt_en !== 1'b1 || strobes !== 4'h0) begin
            n_fail++; $display("FAIL single_hold: got valid=%b ir=%h cnt_en=%b strobes=%h expected 1/%h/1/0",
                               bus.ir_valid, bus.ir_out, bus.pc_cnt_en, strobes, exp_ir);
        end
        n_checks++;
        if (bus.fetch_count !== CW'(exp_count)) begin
            n_fail++; $display("FAIL single_count: got %0d expected %0d", bus.fetch_count, exp_count);
        end
        tick();
        repeat (3) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ir_valid !== 1'b0 || pulses != 1) begin
            n_fail++; $display("FAIL single_done: got busy=%b valid=%b pulses=%0d expected 0/0/1", bus.busy, bus.ir_valid, pulses);
        end
        bus.halt = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset = 1'b1; tick(); reset = 1'b0; exp_count = 0;
        bus.mem_rdy = 1'b1; bus.ir_ready = 1'b1; bus.halt = 1'b0; bus.start = 1'b1; pulses = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.data_in = b2b_data[i];
            if (i == 2) bus.halt = 1'b1;
            n_checks++;
            if (strobes !== 4'hF) begin
                n_fail++; $display("FAIL b2b_addr%0d: got strobes=%h expected f", i, strobes);
            end
            tick();
            tick();
            exp_count = next_count(exp_count);
            exp_ir = b2b_data[i];
            n_checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir || bus.pc_cnt_en !== 1'b1) begin
                n_fail++; $display("FAIL b2b_hold%0d: got valid=%b ir=%h cnt_en=%b expected 1/%h/1",
                                   i, bus.ir_valid, bus.ir_out, bus.pc_cnt_en, exp_ir);
            end
            tick();
        end
        n_checks++;
        if (bus.busy !== 1'b0 || pulses != 3 || bus.fetch_count !== CW'(exp_count)) begin
            n_fail++; $display("FAIL b2b_end: got busy=%b pulses=%0d count=%0d expected 0/3/%0d",
                               bus.busy, pulses, bus.fetch_count, exp_count);
        end
        bus.start = 1'b0; bus.halt = 1'b0;
    endtask

    task automatic test_hold_stall();
        logic [DW-1:0] d;
        d = DW'($urandom);
        bus.mem_rdy = 1'b1; bus.data_in = d; bus.ir_ready = 1'b0;
        bus.start = 1'b1; bus.halt = 1'b0; pulses = 0;
        tick();
        bus.start = 1'b0; bus.halt = 1'b1;
        tick();
        tick();
        exp_count = next_count(exp_count);
        exp_ir = d;
        n_checks++;
        if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir || bus.pc_cnt_en !== 1'b1) begin
            n_fail++; $display("FAIL stall_first: got valid=%b ir=%h cnt_en=%b expected 1/%h/1",
                               bus.ir_valid, bus.ir_out, bus.pc_cnt_en, exp_ir);
        end
        bus.data_in = ~d;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir || bus.pc_cnt_en !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: got valid=%b ir=%h cnt_en=%b busy=%b expected 1/%h/0/1",
                                   i, bus.ir_valid, bus.ir_out, bus.pc_cnt_en, bus.busy, exp_ir);
            end
            if (i == 4) bus.ir_ready = 1'b1;
        end
        tick();
        n_checks++;
        if (bus.ir_valid !== 1'b0 || bus.busy !== 1'b0 || pulses != 1 || bus.fetch_count !== CW'(exp_count)) begin
            n_fail++; $display("FAIL stall_end: got valid=%b busy=%b pulses=%0d count=%0d expected 0/0/1/%0d",
                               bus.ir_valid, bus.busy, pulses, bus.fetch_count, exp_count);
        end
        bus.halt = 1'b0;
    endtask

    task automatic test_random();
        int unsigned d;
        int unsigned r;
        logic [DW-1:0] val;
        bus.halt = 1'b0; bus.start = 1'b1; bus.ir_ready = 1'b0; bus.mem_rdy = 1'b0; pulses = 0;
        tick();
        for (int unsigned k = 0; k < NF; k++) begin
            d = $urandom_range(0, MW - 1);
            r = $urandom_range(0, 3);
            val = DW'($urandom);
            bus.start = 1'($urandom_range(0, 1));
            if (k == NF - 1) bus.halt = 1'b1;
            n_checks++;
            if (strobes !== 4'hF || bus.ir_valid !== 1'b0 || bus.pc_cnt_en !== 1'b0) begin
                n_fail++; $display("FAIL rand_addr%0d: got strobes=%h valid=%b cnt_en=%b expected f/0/0",
                                   k, strobes, bus.ir_valid, bus.pc_cnt_en);
            end
            bus.ir_ready = 1'($urandom_range(0, 1));
            bus.mem_rdy = 1'($urandom_range(0, 1));
            tick();
            for (int unsigned w = 0; w <= d; w++) begin
                n_checks++;
                if (strobes !== 4'hF || bus.ir_valid !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++; $display("FAIL rand_wait%0d_%0d: got strobes=%h valid=%b busy=%b expected f/0/1",
                                       k, w, strobes, bus.ir_valid, bus.busy);
                end
                bus.mem_rdy = (w == d);
                bus.data_in = (w == d) ? val : ~val;
                bus.ir_ready = 1'($urandom_range(0, 1));
                tick();
            end
            exp_count = next_count(exp_count);
            exp_ir = val;
            for (int unsigned h = 0; h <= r; h++) begin
                n_checks++;
                if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir || bus.pc_cnt_en !== logic'(h == 0) ||
                    strobes !== 4'h0 || bus.fetch_count !== CW'(exp_count)) begin
                    n_fail++; $display("FAIL rand_hold%0d_%0d: got valid=%b ir=%h cnt_en=%b strobes=%h count=%0d expected 1/%h/%b/0/%0d",
                                       k, h, bus.ir_valid, bus.ir_out, bus.pc_cnt_en, strobes, bus.fetch_count,
                                       exp_ir, (h == 0), exp_count);
                end
                bus.ir_ready = (h == r);
                bus.mem_rdy = 1'($urandom_range(0, 1));
                tick();
            end
        end
        n_checks++;
        if (bus.busy !== 1'b0 || pulses != int'(NF)) begin
            n_fail++; $display("FAIL rand_end: got busy=%b pulses=%0d expected 0/%0d", bus.busy, pulses, NF);
        end
        bus.halt = 1'b0; bus.start = 1'b0; bus.ir_ready = 1'b0;
    endtask

    task automatic test_timeout();
        bus.mem_rdy = 1'b0; bus.ir_ready = 1'b1; bus.start = 1'b1; bus.halt = 1'b0; pulses = 0;
        tick();
        bus.start = 1'b0;
        n_checks++;
        if (strobes !== 4'hF) begin
            n_fail++; $display("FAIL tmo_addr: got strobes=%h expected f", strobes);
        end
        tick();
        for (int unsigned w = 0; w < MW; w++) begin
            n_checks++;
            if (strobes !== 4'hF || bus.busy !== 1'b1 || bus.err !== 1'b0) begin
                n_fail++; $display("FAIL tmo_wait%0d: got strobes=%h busy=%b err=%b expected f/1/0", w, strobes, bus.busy, bus.err);
            end
            tick();
        end
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || strobes !== 4'h0 || bus.ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL tmo_err: got err=%b busy=%b strobes=%h valid=%b expected 1/0/0/0",
                               bus.err, bus.busy, strobes, bus.ir_valid);
        end
        n_checks++;
        if (pulses != 0 || bus.fetch_count !== CW'(exp_count) || bus.ir_out !== exp_ir) begin
            n_fail++; $display("FAIL tmo_state: got pulses=%0d count=%0d ir=%h expected 0/%0d/%h",
                               pulses, bus.fetch_count, bus.ir_out, exp_count, exp_ir);
        end
        bus.start = 1'b1; bus.mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
                n_fail++; $display("FAIL tmo_sticky%0d: got busy=%b err=%b expected 0/1", i, bus.busy, bus.err);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_halt_reset();
        reset = 1'b1; tick(); reset = 1'b0; exp_count = 0; exp_ir = '0;
        n_checks++;
        if (bus.err !== 1'b0 || bus.fetch_count !== 2'd0) begin
            n_fail++; $display("FAIL hr_reset_err: got err=%b count=%0d expected 0/0", bus.err, bus.fetch_count);
        end
        bus.mem_rdy = 1'b1; bus.ir_ready = 1'b1; bus.start = 1'b1; bus.halt = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.data_in = DW'(i * 37 + 5);
            tick();
            if (i == 3) bus.halt = 1'b1;
            tick();
            exp_count = next_count(exp_count);
            exp_ir = DW'(i * 37 + 5);
            n_checks++;
            if (bus.fetch_count !== CW'(exp_count) || bus.ir_out !== exp_ir || bus.ir_valid !== 1'b1) begin
                n_fail++; $display("FAIL hr_fetch%0d: got count=%0d ir=%h valid=%b expected %0d/%h/1",
                                   i, bus.fetch_count, bus.ir_out, bus.ir_valid, exp_count, exp_ir);
            end
            tick();
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.fetch_count !== 2'd0) begin
            n_fail++; $display("FAIL hr_halt_wrap: got busy=%b count=%0d expected 0/0", bus.busy, bus.fetch_count);
        end
        bus.halt = 1'b0;
        tick();
        bus.start = 1'b0;
        n_checks++;
        if (strobes !== 4'hF) begin
            n_fail++; $display("FAIL hr_addr: got strobes=%h expected f", strobes);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        n_checks++;
        if ({strobes, bus.pc_cnt_en, bus.ir_valid, bus.busy, bus.err} !== 8'h00 ||
            bus.fetch_count !== CW'(exp_count) || bus.ir_out !== 8'h00) begin
            n_fail++; $display("FAIL hr_mid_reset: got flags=%b count=%0d ir=%h expected 00000000/0/00",
                               {strobes, bus.pc_cnt_en, bus.ir_valid, bus.busy, bus.err}, bus.fetch_count, bus.ir_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_stall();
        test_random();
        test_timeout();
        test_halt_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
